// File: rtl/rvfi_check_pkg.sv
// Shared definitions for the rvfi_* trace checkers: failure codes, checker FSM
// states and a saturating counter helper.
package rvfi_check_pkg;

  localparam logic [2:0] CHK_NONE  = 3'd0;
  localparam logic [2:0] CHK_RS1   = 3'd1;
  localparam logic [2:0] CHK_RS2   = 3'd2;
  localparam logic [2:0] CHK_X0    = 3'd3;
  localparam logic [2:0] CHK_ORDER = 3'd4;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAIL  = 2'd3
  } chk_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/rvfi_order_tracker.sv
// Expected rvfi_order register and per-channel match logic; only instantiated
// by rvfi_regfile_check when RISCV_FORMAL_REGCHK_ORDER_EN is defined.
module rvfi_order_tracker #(
  parameter int NRET    = 1,
  parameter int ORDER_W = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [NRET-1:0]         i_valid,
  input  logic [NRET*ORDER_W-1:0] i_order,
  output logic [NRET-1:0]         o_order_ok
);

  logic               r_have;
  logic [ORDER_W-1:0] r_expect;
  logic               w_have;
  logic [ORDER_W-1:0] w_expect;

  // The first valid retirement seeds the expectation; each valid channel then
  // consumes one sequence number, so invalid channels leave no gap.
  always_comb begin
    w_have     = r_have;
    w_expect   = r_expect;
    o_order_ok = '1;
    for (int c = 0; c < NRET; c++) begin
      if (i_valid[c]) begin
        if (w_have) begin
          o_order_ok[c] = (i_order[c*ORDER_W +: ORDER_W] == w_expect);
        end else begin
          w_expect = i_order[c*ORDER_W +: ORDER_W];
        end
        w_have   = 1'b1;
        w_expect = w_expect + ORDER_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_have   <= 1'b0;
      r_expect <= '0;
    end else if (i_en) begin
      r_have   <= w_have;
      r_expect <= w_expect;
    end
  end

endmodule

// File: rtl/rvfi_regfile_check.sv
// RVFI register-file consistency checker: shadows NTRACK registers across NRET
// channels and latches the first failure. Order check under RISCV_FORMAL_REGCHK_ORDER_EN.
module rvfi_regfile_check
  import rvfi_check_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter int NTRACK    = 2,
  parameter int ORDER_W   = 64,
  parameter int ZERO_INIT = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NTRACK*5-1:0]     track_idx,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET-1:0]         rvfi_trap,
  input  logic [NRET*5-1:0]       rvfi_rs1_addr,
  input  logic [NRET*5-1:0]       rvfi_rs2_addr,
  input  logic [NRET*5-1:0]       rvfi_rd,
  input  logic [NRET*XLEN-1:0]    rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]    rvfi_rs2_rdata,
  input  logic [NRET*XLEN-1:0]    rvfi_post_rd,
  output logic                    chk_fail,
  output logic [2:0]              chk_code,
  output logic [7:0]              chk_chan,
  output logic [ORDER_W-1:0]      chk_order,
  output logic [31:0]             chk_count,
  output chk_state_e              dbg_state
);

  chk_state_e       r_state;
  logic [4:0]       r_track   [NTRACK];
  logic [XLEN-1:0]  r_shadow  [NTRACK];
  logic [NTRACK-1:0] r_written;

  logic [XLEN-1:0]    w_shadow [NTRACK];
  logic [NTRACK-1:0]  w_written;
  logic               w_fail;
  logic [2:0]         w_code;
  logic [7:0]         w_chan;
  logic [ORDER_W-1:0] w_order;
  logic [31:0]        w_nvalid;
  logic [NRET-1:0]    w_order_ok;

`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
  rvfi_order_tracker #(
    .NRET    (NRET),
    .ORDER_W (ORDER_W)
  ) u_order (
    .i_clk      (clk),
    .i_rst_n    (resetn),
    .i_en       (r_state == ST_RUN),
    .i_valid    (rvfi_valid),
    .i_order    (rvfi_order),
    .o_order_ok (w_order_ok)
  );
`else
  assign w_order_ok = '1;
`endif

  // Channels walk in ascending order against a working copy of the shadows, so
  // a later channel observes earlier same-cycle writes.
  always_comb begin : proc_check
    logic [4:0]      rs1a, rs2a, rda;
    logic [XLEN-1:0] rs1d, rs2d, postd;
    logic            bad1, bad2, badx;
    logic [2:0]      code;
    w_shadow  = r_shadow;
    w_written = r_written;
    w_fail    = 1'b0;
    w_code    = CHK_NONE;
    w_chan    = '0;
    w_order   = '0;
    w_nvalid  = '0;
    rs1a = '0; rs2a = '0; rda = '0;
    rs1d = '0; rs2d = '0; postd = '0;
    bad1 = 1'b0; bad2 = 1'b0; badx = 1'b0;
    code = CHK_NONE;
    for (int c = 0; c < NRET; c++) begin
      rs1a  = rvfi_rs1_addr[c*5 +: 5];
      rs2a  = rvfi_rs2_addr[c*5 +: 5];
      rda   = rvfi_rd[c*5 +: 5];
      rs1d  = rvfi_rs1_rdata[c*XLEN +: XLEN];
      rs2d  = rvfi_rs2_rdata[c*XLEN +: XLEN];
      postd = rvfi_post_rd[c*XLEN +: XLEN];
      bad1  = 1'b0;
      bad2  = 1'b0;
      for (int k = 0; k < NTRACK; k++) begin
        if (w_written[k] && r_track[k] == rs1a && w_shadow[k] != rs1d) bad1 = 1'b1;
        if (w_written[k] && r_track[k] == rs2a && w_shadow[k] != rs2d) bad2 = 1'b1;
      end
      badx = (rs1a == 5'd0 && rs1d != '0) || (rs2a == 5'd0 && rs2d != '0) ||
             (rda == 5'd0 && postd != '0);
      if (bad1)               code = CHK_RS1;
      else if (bad2)          code = CHK_RS2;
      else if (badx)          code = CHK_X0;
      else if (!w_order_ok[c]) code = CHK_ORDER;
      else                    code = CHK_NONE;
      if (rvfi_valid[c]) begin
        w_nvalid = w_nvalid + 32'd1;
        if (!w_fail && code != CHK_NONE) begin
          w_fail  = 1'b1;
          w_code  = code;
          w_chan  = 8'(c);
          w_order = rvfi_order[c*ORDER_W +: ORDER_W];
        end
        if (!rvfi_trap[c]) begin
          for (int k = 0; k < NTRACK; k++) begin
            if (r_track[k] == rda) begin
              w_shadow[k]  = postd;
              w_written[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_RESET;
      for (int k = 0; k < NTRACK; k++) begin
        r_track[k]  <= '0;
        r_shadow[k] <= '0;
      end
      r_written <= {NTRACK{ZERO_INIT != 0}};
      chk_fail  <= 1'b0;
      chk_code  <= CHK_NONE;
      chk_chan  <= '0;
      chk_order <= '0;
      chk_count <= '0;
    end else begin
      case (r_state)
        ST_RESET: r_state <= ST_ARM;
        ST_ARM: begin
          for (int k = 0; k < NTRACK; k++) r_track[k] <= track_idx[k*5 +: 5];
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_shadow  <= w_shadow;
          r_written <= w_written;
          chk_count <= sat_add32(chk_count, w_nvalid);
          if (w_fail) begin
            chk_fail  <= 1'b1;
            chk_code  <= w_code;
            chk_chan  <= w_chan;
            chk_order <= w_order;
            r_state   <= ST_FAIL;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_rvfi_regfile_check.sv
// Bench for rvfi_regfile_check (NRET=2): directed vector table, reset sequences,
// then random retirements checked against a whole-register-file reference model.
`timescale 1ns/1ps
module tb_rvfi_regfile_check;
  import rvfi_check_pkg::*;

  typedef struct {
    logic        valid;
    logic        trap;
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1d, rs2d, post;
    logic [63:0] order;
  } ret_t;

  typedef struct {
    bit          rst;
    ret_t        ch0, ch1;
    logic [2:0]  code;
    logic [7:0]  chan;
    logic [31:0] count;
    logic [63:0] order;
  } vec_t;

  // clock / reset
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]   t_idx0, t_idx1;
  ret_t         cur0, cur1;
  logic [9:0]   track_idx;
  logic [1:0]   rvfi_valid, rvfi_trap;
  logic [127:0] rvfi_order;
  logic [9:0]   rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd;
  logic [63:0]  rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_post_rd;
  logic         chk_fail;
  logic [2:0]   chk_code;
  logic [7:0]   chk_chan;
  logic [63:0]  chk_order;
  logic [31:0]  chk_count;
  chk_state_e   dbg_state;

  assign track_idx      = {t_idx1, t_idx0};
  assign rvfi_valid     = {cur1.valid, cur0.valid};
  assign rvfi_trap      = {cur1.trap, cur0.trap};
  assign rvfi_order     = {cur1.order, cur0.order};
  assign rvfi_rs1_addr  = {cur1.rs1a, cur0.rs1a};
  assign rvfi_rs2_addr  = {cur1.rs2a, cur0.rs2a};
  assign rvfi_rd        = {cur1.rd, cur0.rd};
  assign rvfi_rs1_rdata = {cur1.rs1d, cur0.rs1d};
  assign rvfi_rs2_rdata = {cur1.rs2d, cur0.rs2d};
  assign rvfi_post_rd   = {cur1.post, cur0.post};

  rvfi_regfile_check #(
    .XLEN(32), .NRET(2), .NTRACK(2), .ORDER_W(64), .ZERO_INIT(0)
  ) dut (
    .clk(clk), .resetn(resetn), .track_idx(track_idx),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_trap(rvfi_trap),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd(rvfi_rd),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_post_rd(rvfi_post_rd),
    .chk_fail(chk_fail), .chk_code(chk_code), .chk_chan(chk_chan),
    .chk_order(chk_order), .chk_count(chk_count), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // reference model: full architectural register file, only tracked indices checked
  logic [31:0] m_val [32];
  bit          m_known [32];
  int          m_edges;
  bit          m_failed;
  logic [2:0]  m_code;
  logic [7:0]  m_chan;
  logic [63:0] m_ord;
  logic [31:0] m_count;
  bit          m_have_exp;
  logic [63:0] m_exp;

  function automatic bit tracked(input logic [4:0] r);
    return (r == t_idx0) || (r == t_idx1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_known[i] = 1'b0;
    end
    m_edges = 0; m_failed = 0; m_code = CHK_NONE; m_chan = '0; m_ord = '0;
    m_count = '0; m_have_exp = 0; m_exp = '0;
  endtask

  task automatic model_ret(input ret_t r, input int c);
    logic [2:0] code;
    if (!r.valid) return;
    if (m_count != 32'hFFFF_FFFF) m_count++;
    code = CHK_NONE;
    if (tracked(r.rs1a) && m_known[r.rs1a] && m_val[r.rs1a] != r.rs1d) code = CHK_RS1;
    else if (tracked(r.rs2a) && m_known[r.rs2a] && m_val[r.rs2a] != r.rs2d) code = CHK_RS2;
    else if ((r.rs1a == 0 && r.rs1d != 0) || (r.rs2a == 0 && r.rs2d != 0) ||
             (r.rd == 0 && r.post != 0)) code = CHK_X0;
`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
    else if (m_have_exp && r.order != m_exp) code = CHK_ORDER;
    m_exp = m_have_exp ? m_exp + 64'd1 : r.order + 64'd1;
    m_have_exp = 1;
`endif
    if (code != CHK_NONE && !m_failed) begin
      m_failed = 1; m_code = code; m_chan = 8'(c); m_ord = r.order;
    end
    if (!r.trap && tracked(r.rd)) begin
      m_val[r.rd] = r.post;
      m_known[r.rd] = 1;
    end
  endtask

  // The first two edges after reset release are the RESET and ARM cycles.
  task automatic model_edge();
    if (m_edges < 2) begin
      m_edges++;
      return;
    end
    if (m_failed) return;
    model_ret(cur0, 0);
    model_ret(cur1, 1);
  endtask

  task automatic compare_model();
    chk("m_fail", 64'(chk_fail), 64'(m_failed));
    chk("m_code", 64'(chk_code), 64'(m_code));
    chk("m_chan", 64'(chk_chan), 64'(m_chan));
    chk("m_order", chk_order, m_ord);
    chk("m_count", 64'(chk_count), 64'(m_count));
  endtask

  // driver tasks
  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  function automatic ret_t mk(bit v, bit t, logic [4:0] a1, logic [31:0] d1,
                              logic [4:0] a2, logic [31:0] d2, logic [4:0] rd,
                              logic [31:0] post, logic [63:0] ord);
    ret_t r;
    r.valid = v; r.trap = t; r.rs1a = a1; r.rs1d = d1; r.rs2a = a2; r.rs2d = d2;
    r.rd = rd; r.post = post; r.order = ord;
    return r;
  endfunction

  task automatic do_reset(input logic [4:0] a, input logic [4:0] b);
    ret_t junk;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_fail", 64'(chk_fail), 64'd0);
    chk("rst_code", 64'(chk_code), 64'd0);
    chk("rst_chan", 64'(chk_chan), 64'd0);
    chk("rst_order", chk_order, 64'd0);
    chk("rst_count", 64'(chk_count), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_RESET));
    model_reset();
    t_idx0 = a;
    t_idx1 = b;
    @(negedge clk);
    resetn = 1'b1;
    // would be an x0 failure on both channels if it were checked
    junk = mk(1, 0, 5'd0, 32'd5, 5'd0, 32'd5, 5'd0, 32'd1, 64'($urandom));
    cur0 = junk;
    cur1 = junk;
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    chk("arm_count", 64'(chk_count), 64'd0);
    chk("arm_fail", 64'(chk_fail), 64'd0);
    chk("arm_state", 64'(dbg_state), 64'(ST_RUN));
    cur0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur1 = cur0;
  endtask

  // random stimulus generation
  logic [63:0] gen_ord;

  function automatic logic [4:0] pick_reg();
    int s;
    s = $urandom_range(0, 9);
    if (s <= 3) return t_idx0;
    if (s <= 6) return t_idx1;
    if (s == 7) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  task automatic gen_cycle();
    logic [31:0] gv [32];
    bit          gk [32];
    ret_t        r  [2];
    for (int i = 0; i < 32; i++) begin
      gv[i] = m_val[i];
      gk[i] = m_known[i];
    end
    for (int c = 0; c < 2; c++) begin
      r[c].valid = ($urandom_range(0, 3) != 0);
      r[c].trap  = ($urandom_range(0, 7) == 0);
      r[c].rs1a  = pick_reg();
      r[c].rs1d  = (r[c].rs1a == 0) ? 32'd0 : (gk[r[c].rs1a] ? gv[r[c].rs1a] : $urandom);
      r[c].rs2a  = pick_reg();
      r[c].rs2d  = (r[c].rs2a == 0) ? 32'd0 : (gk[r[c].rs2a] ? gv[r[c].rs2a] : $urandom);
      r[c].rd    = pick_reg();
      r[c].post  = (r[c].rd == 0) ? 32'd0 : $urandom;
      r[c].order = gen_ord;
      if (r[c].valid) gen_ord = gen_ord + 64'd1;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0:       r[c].rs1d = r[c].rs1d ^ 32'h1;
          1:       r[c].rs2d = r[c].rs2d ^ 32'h100;
          2:       begin r[c].rd = 5'd0; r[c].post = 32'd7; end
          default: r[c].order = r[c].order + 64'd2;
        endcase
      end
      if (r[c].valid && !r[c].trap && r[c].rd != 0) begin
        gv[r[c].rd] = r[c].post;
        gk[r[c].rd] = 1;
      end
    end
    cur0 = r[0];
    cur1 = r[1];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [$];
    ret_t        idle;
    logic [2:0]  e_code, h_code;
    logic [63:0] e_ord, h_ord;
    logic [7:0]  h_chan;
    int          post_fail;

    resetn = 1'b0;
    t_idx0 = 5'd5;
    t_idx1 = 5'd7;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur0 = idle;
    cur1 = idle;
    model_reset();

`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
    e_code = CHK_ORDER; e_ord = 64'd6;
    h_code = CHK_ORDER; h_ord = 64'd52; h_chan = 8'd1;
`else
    e_code = CHK_NONE; e_ord = 64'd0;
    h_code = CHK_NONE; h_ord = 64'd0; h_chan = 8'd0;
`endif

    // write, read back, trap suppression, rs2 mismatch, FAIL hold
    tbl.push_back('{1, mk(1,0,0,0,0,0,5,32'h1234,10), idle, CHK_NONE, 0, 1, 0});
    tbl.push_back('{0, mk(1,0,5,32'h1234,0,0,0,0,11), idle, CHK_NONE, 0, 2, 0});
    tbl.push_back('{0, mk(1,1,0,0,0,0,5,32'h99,12), idle, CHK_NONE, 0, 3, 0});
    tbl.push_back('{0, mk(1,0,5,32'h1234,0,0,0,0,13), idle, CHK_NONE, 0, 4, 0});
    tbl.push_back('{0, mk(1,0,0,0,5,32'h1235,0,0,14), idle, CHK_RS2, 0, 5, 14});
    tbl.push_back('{0, mk(1,0,5,32'h1,0,0,0,0,15), idle, CHK_RS2, 0, 5, 14});
    // same-cycle forwarding from ch0 to ch1
    tbl.push_back('{1, mk(1,0,0,0,0,0,7,32'hA,0), mk(1,0,7,32'hA,0,0,0,0,1), CHK_NONE, 0, 2, 0});
    tbl.push_back('{0, mk(1,0,0,0,0,0,7,32'hC,2), mk(1,0,7,32'hB,0,0,0,0,3), CHK_RS1, 1, 4, 3});
    // trapped write must not be seen by a later read
    tbl.push_back('{1, mk(1,0,0,0,0,0,5,32'h1234,20), idle, CHK_NONE, 0, 1, 0});
    tbl.push_back('{0, mk(1,1,0,0,0,0,5,32'h99,21), idle, CHK_NONE, 0, 2, 0});
    tbl.push_back('{0, mk(1,0,5,32'h99,0,0,0,0,22), idle, CHK_RS1, 0, 3, 22});
    // unwritten reads, channel gap, x0 write
    tbl.push_back('{1, mk(1,0,5,32'hDEAD,0,0,0,0,100), idle, CHK_NONE, 0, 1, 0});
    tbl.push_back('{0, idle, mk(1,0,0,0,7,32'h55,0,0,101), CHK_NONE, 0, 2, 0});
    tbl.push_back('{0, mk(1,0,0,0,0,0,0,32'h1,102), idle, CHK_X0, 0, 3, 102});
    // order wrap
    tbl.push_back('{1, mk(1,0,0,0,0,0,9,32'h3,64'hFFFF_FFFF_FFFF_FFFF), idle, CHK_NONE, 0, 1, 0});
    tbl.push_back('{0, mk(1,0,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0,1), CHK_NONE, 0, 3, 0});
    // order skip on ch0, then on ch1
    tbl.push_back('{1, mk(1,0,0,0,0,0,0,0,4), idle, CHK_NONE, 0, 1, 0});
    tbl.push_back('{0, mk(1,0,0,0,0,0,0,0,6), idle, e_code, 0, 2, e_ord});
    tbl.push_back('{1, mk(1,0,0,0,0,0,0,0,50), mk(1,0,0,0,0,0,0,0,52), h_code, h_chan, 2, h_ord});
    // rs1 has priority over rs2; x0 read
    tbl.push_back('{1, mk(1,0,0,0,0,0,5,32'h1,0), idle, CHK_NONE, 0, 1, 0});
    tbl.push_back('{0, mk(1,0,5,32'h2,5,32'h3,0,0,1), idle, CHK_RS1, 0, 2, 1});
    tbl.push_back('{1, mk(1,0,0,0,0,32'h7,0,0,0), idle, CHK_X0, 0, 1, 0});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(5'd5, 5'd7);
      cur0 = tbl[i].ch0;
      cur1 = tbl[i].ch1;
      run_cycle();
      chk($sformatf("v%0d_fail", i), 64'(chk_fail), 64'(tbl[i].code != CHK_NONE));
      chk($sformatf("v%0d_code", i), 64'(chk_code), 64'(tbl[i].code));
      chk($sformatf("v%0d_chan", i), 64'(chk_chan), 64'(tbl[i].chan));
      chk($sformatf("v%0d_count", i), 64'(chk_count), 64'(tbl[i].count));
      chk($sformatf("v%0d_order", i), chk_order, tbl[i].order);
    end

    // randomized phase against the model, with fresh (possibly duplicate) tracking
    for (int s = 0; s < 5; s++) begin
      logic [4:0] a, b;
      a = 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      do_reset(a, b);
      gen_ord = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFF0 : {32'd0, $urandom};
      post_fail = 0;
      for (int n = 0; n < 300 && post_fail < 4; n++) begin
        gen_cycle();
        run_cycle();
        if (m_failed) post_fail++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
